// File: rtl/load_arbiter_pkg.sv
// Shared definitions for the load arbiter: default widths and FSM state encoding.
package load_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 16;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/load_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above ptr (with wrap) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the offset closest to ptr is the last writer.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        idx = IDW'(sum - (IDW+1)'(NREQ));
      end else begin
        idx = sum[IDW-1:0];
      end
      gnt_id = req[idx] ? idx : gnt_id;
      any    = any | req[idx];
    end
  end

endmodule

// File: rtl/load_arbiter.sv
// Round-robin arbiter sharing one step-enabled load register among NREQ requesters.
// Optional load counter output enabled by defining LDARB_LOADCNT_EN.
module load_arbiter
  import load_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din_flat,
  output logic [W-1:0]      ld_data,
  output logic              step,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy
`ifdef LDARB_LOADCNT_EN
  ,
  output logic [15:0]       load_cnt
`endif
);

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_pick;
  logic           pick_any;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .gnt_id (gnt_pick),
    .any    (pick_any)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_any) state_next = LOAD;
        else          state_next = IDLE;
      end
      LOAD:    state_next = ACK;
      ACK:     state_next = RELEASE;
      // Only the current winner's request releases the arbiter.
      RELEASE: begin
        if (!req[gnt_id]) state_next = IDLE;
        else              state_next = RELEASE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_id <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_any) begin
        gnt_id <= gnt_pick;
      end
      if (state == LOAD) begin
        ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
    end
  end

  // Moore outputs; async reset of state drops step without waiting for a clock.
  always_comb begin
    step    = (state == LOAD);
    busy    = (state != IDLE);
    ld_data = '0;
    ack     = '0;
    if (state == LOAD) ld_data = din_flat[int'(gnt_id)*W +: W];
    else               ld_data = '0;
    if (state == ACK) ack = NREQ'(1) << gnt_id;
    else              ack = '0;
  end

`ifdef LDARB_LOADCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt <= 16'd0;
    end else if (state == LOAD) begin
      load_cnt <= load_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_arbiter.sv
// Directed self-checking bench for load_arbiter; LDARB_LOADCNT_EN adds the counter test.
module tb_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] din_flat;
  logic [15:0] ld_data;
  logic        step;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;
`ifdef LDARB_LOADCNT_EN
  logic [15:0] load_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  load_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din_flat (din_flat),
    .ld_data  (ld_data),
    .step     (step),
    .ack      (ack),
    .gnt_id   (gnt_id),
    .busy     (busy)
`ifdef LDARB_LOADCNT_EN
    ,
    .load_cnt (load_cnt)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_step(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (step === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: step not seen within 20 cycles", name);
    end
  endtask

  task automatic wait_ack(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (ack !== 4'b0000) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: ack not seen within 20 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: busy still high after 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    req      = 4'b1111;
    din_flat = 64'h4444_3333_2222_1111;
    repeat (3) @(negedge clk);
    checks++; if (step !== 1'b0)         begin fails++; $display("FAIL reset_step: got %b want 0", step); end
    checks++; if (ack !== 4'b0000)       begin fails++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ld_data !== 16'h0000)  begin fails++; $display("FAIL reset_ld_data: got %h want 0000", ld_data); end
    checks++; if (gnt_id !== 2'd0)       begin fails++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    req = 4'b0000;
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    din_flat = 64'h0000_BEEF_0000_0000;
    req      = 4'b0100;
    @(negedge clk);
    checks++; if (step !== 1'b1)         begin fails++; $display("FAIL single_step: got %b want 1", step); end
    checks++; if (ld_data !== 16'hBEEF)  begin fails++; $display("FAIL single_ld_data: got %h want beef", ld_data); end
    checks++; if (gnt_id !== 2'd2)       begin fails++; $display("FAIL single_gnt_id: got %0d want 2", gnt_id); end
    checks++; if (ack !== 4'b0000)       begin fails++; $display("FAIL single_ack_in_load: got %b want 0000", ack); end
    @(negedge clk);
    checks++; if (ack !== 4'b0100)       begin fails++; $display("FAIL single_ack: got %b want 0100", ack); end
    checks++; if (step !== 1'b0)         begin fails++; $display("FAIL single_step_in_ack: got %b want 0", step); end
    checks++; if (ld_data !== 16'h0000)  begin fails++; $display("FAIL single_ld_data_in_ack: got %h want 0000", ld_data); end
    @(negedge clk);
    checks++; if (ack !== 4'b0000)       begin fails++; $display("FAIL single_ack_once: got %b want 0000", ack); end
    checks++; if (busy !== 1'b1)         begin fails++; $display("FAIL single_release_busy: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1)         begin fails++; $display("FAIL single_release_hold: got %b want 1", busy); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0)         begin fails++; $display("FAIL single_back_idle: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int         steps = 0;
    logic [3:0] exp_ack;
    do_reset();
    din_flat = 64'hDDDD_CCCC_BBBB_AAAA;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_step("rr_wait_step");
      if (step === 1'b1) steps++;
      checks++; if (gnt_id !== exp_seq[i]) begin fails++; $display("FAIL rr_gnt_id[%0d]: got %0d want %0d", i, gnt_id, exp_seq[i]); end
      wait_ack("rr_wait_ack");
      exp_ack = 4'b0001 << exp_seq[i];
      checks++; if (ack !== exp_ack) begin fails++; $display("FAIL rr_ack[%0d]: got %b want %b", i, ack, exp_ack); end
      req[exp_seq[i]] = 1'b0;
      wait_idle("rr_wait_idle");
      req = 4'b1111;
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (steps !== 5) begin fails++; $display("FAIL rr_step_count: got %0d want 5", steps); end
  endtask

  task automatic test_ptr_wrap();
    din_flat = 64'h9999_8888_7777_1234;
    req      = 4'b0100;
    wait_step("wrap_pre_step");
    wait_ack("wrap_pre_ack");
    req = 4'b0000;
    wait_idle("wrap_pre_idle");
    req = 4'b1001;
    wait_step("wrap_step3");
    checks++; if (gnt_id !== 2'd3)        begin fails++; $display("FAIL wrap_gnt3: got %0d want 3", gnt_id); end
    checks++; if (ld_data !== 16'h9999)   begin fails++; $display("FAIL wrap_data3: got %h want 9999", ld_data); end
    wait_ack("wrap_ack3");
    checks++; if (ack !== 4'b1000)        begin fails++; $display("FAIL wrap_ack3: got %b want 1000", ack); end
    req = 4'b0001;
    wait_idle("wrap_idle3");
    wait_step("wrap_step0");
    checks++; if (gnt_id !== 2'd0)        begin fails++; $display("FAIL wrap_gnt0: got %0d want 0", gnt_id); end
    checks++; if (ld_data !== 16'h1234)   begin fails++; $display("FAIL wrap_data0: got %h want 1234", ld_data); end
    wait_ack("wrap_ack0");
    checks++; if (ack !== 4'b0001)        begin fails++; $display("FAIL wrap_ack0: got %b want 0001", ack); end
    req = 4'b0000;
    wait_idle("wrap_idle0");
  endtask

  task automatic test_reset_mid_load();
    bit saw_ack = 1'b0;
    din_flat = 64'h0000_0000_5A5A_0000;
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk);
    #2;
    checks++; if (step !== 1'b1)          begin fails++; $display("FAIL midload_step_before: got %b want 1", step); end
    #1 rst = 1'b0;
    #1;
    checks++; if (step !== 1'b0)          begin fails++; $display("FAIL midload_step_async: got %b want 0", step); end
    checks++; if (ld_data !== 16'h0000)   begin fails++; $display("FAIL midload_ld_data: got %h want 0000", ld_data); end
    checks++; if (busy !== 1'b0)          begin fails++; $display("FAIL midload_busy: got %b want 0", busy); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ack !== 4'b0000) saw_ack = 1'b1;
    end
    req = 4'b0000;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ack !== 4'b0000) saw_ack = 1'b1;
    end
    checks++; if (saw_ack !== 1'b0)       begin fails++; $display("FAIL midload_no_ack: got %b want 0", saw_ack); end
    checks++; if (busy !== 1'b0)          begin fails++; $display("FAIL midload_idle_after: got %b want 0", busy); end
  endtask

`ifdef LDARB_LOADCNT_EN
  task automatic test_loadcnt();
    do_reset();
    checks++; if (load_cnt !== 16'd0)     begin fails++; $display("FAIL loadcnt_reset: got %0d want 0", load_cnt); end
    for (int i = 0; i < 3; i++) begin
      req = 4'b0001;
      wait_ack("loadcnt_ack");
      req = 4'b0000;
      wait_idle("loadcnt_idle");
    end
    checks++; if (load_cnt !== 16'd3)     begin fails++; $display("FAIL loadcnt_three: got %0d want 3", load_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_reset_mid_load();
`ifdef LDARB_LOADCNT_EN
    test_loadcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
